// File: rtl/sipo_deserializer_pkg.sv
// sipo_deserializer_pkg
//   Shared types and helpers for the SIPO deserializer slice.
//   - state_t : FSM states (ST_COLLECT gathers data bits, ST_PARITY waits for
//               the even-parity bit when SIPO_PARITY_EN is defined)
//   - cnt_w() : bit-counter width for a given word width
package sipo_deserializer_pkg;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_PARITY  = 1'b1
   } state_t;

   // Counter must hold 0..WIDTH-1; sized as $clog2(WIDTH+1) for headroom.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg
//   WIDTH-bit shift register with enable and synchronous active-low clear.
//   MSB_FIRST=1 shifts toward the MSB (first bit ends up in q[WIDTH-1]),
//   MSB_FIRST=0 shifts toward the LSB (first bit ends up in q[0]).
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous clear, active-low
//   en     in   shift din in this edge
//   din    in   serial bit
//   q      out  current register contents
//   q_nxt  out  value q would take if shifted this edge (includes din)
module sipo_shift_reg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             din,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_nxt
);

   always_comb begin
      if (MSB_FIRST) q_nxt = {q[WIDTH-2:0], din};
      else           q_nxt = {din, q[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n)  q <= '0;
      else if (en) q <= q_nxt;
   end

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer
//   Serial-in/parallel-out stage fed by a DFlipFlop Q stream. Qualified bits
//   are shifted into a WIDTH-bit word that is offered on a valid/ready port.
//   The serial side cannot be stalled: a word completing while the output
//   slot is still occupied is dropped and flagged on the sticky overrun bit.
//   Optional feature macro: SIPO_PARITY_EN -- one extra even-parity bit
//   follows each word; the word is delivered on the parity-bit edge and
//   parity_err reports (^word)^parity_bit. Undefined: parity_err tied 0.
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   synchronous reset, active-low
//   din         in   serial data bit
//   din_valid   in   din is sampled this edge
//   frame_sync  in   restart word alignment (din with it counts as bit 0)
//   dout        out  assembled word
//   dout_valid  out  dout holds an unconsumed word
//   dout_ready  in   consumer accepts dout this edge
//   overrun     out  sticky: a completed word was dropped
//   clr_ovr     in   clears overrun (a simultaneous drop wins)
//   parity_err  out  parity result for current dout
module sipo_deserializer
   import sipo_deserializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             din_valid,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             overrun,
   input  logic             clr_ovr,
   output logic             parity_err
);

   localparam int                CNT_W = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] shreg, shreg_nxt, word;
   logic             shift_en, last_bit, word_done, slot_free;

   sipo_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (shift_en),
      .din   (din),
      .q     (shreg),
      .q_nxt (shreg_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_COLLECT;
      else        state <= state_nxt;
   end

   // word_done marks the delivery edge: last data bit without parity, the
   // parity bit with it. In PARITY the register already holds the full word.
   always_comb begin
      state_nxt = state;
      shift_en  = 1'b0;
      word_done = 1'b0;
      last_bit  = (bit_cnt == LAST);
      case (state)
         ST_COLLECT: begin
            shift_en = din_valid;
            if (din_valid && !frame_sync && last_bit) begin
`ifdef SIPO_PARITY_EN
               state_nxt = ST_PARITY;
`else
               word_done = 1'b1;
`endif
            end
         end
         ST_PARITY: begin
            if (frame_sync) begin
               // word discarded; a qualified bit on this edge starts the next one
               state_nxt = ST_COLLECT;
               shift_en  = din_valid;
            end else if (din_valid) begin
               state_nxt = ST_COLLECT;
               word_done = 1'b1;
            end
         end
         default: state_nxt = ST_COLLECT;
      endcase
   end

   assign word      = (state == ST_PARITY) ? shreg : shreg_nxt;
   assign slot_free = !dout_valid || dout_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_cnt <= '0;
      end else if (frame_sync) begin
         bit_cnt <= din_valid ? CNT_W'(1) : '0;
      end else if (state == ST_COLLECT && din_valid) begin
         bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (word_done && slot_free) begin
            dout       <= word;
            dout_valid <= 1'b1;
         end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end

         if (word_done && !slot_free) overrun <= 1'b1;
         else if (clr_ovr)            overrun <= 1'b0;
      end
   end

`ifdef SIPO_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst_n)                      parity_err <= 1'b0;
      else if (word_done && slot_free) parity_err <= (^shreg) ^ din;
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

`ifdef SIPO_PARITY_EN
   localparam int NBITS = 9;
`else
   localparam int NBITS = 8;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;
   logic       frame_sync = 1'b0;
   logic       dout_ready = 1'b1;
   logic       clr_ovr = 1'b0;
   logic [7:0] dout, dout1;
   logic       dout_valid, dout_valid1, overrun, overrun1, parity_err, parity_err1;

   int         total = 0;
   int         bad = 0;
   logic [8:0] sb[$];
   logic       pv = 1'b0;
   logic       pr = 1'b0;

   always #5 clk = ~clk;

   sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .frame_sync(frame_sync), .dout(dout), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .overrun(overrun), .clr_ovr(clr_ovr),
      .parity_err(parity_err)
   );

   sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .frame_sync(frame_sync), .dout(dout1), .dout_valid(dout_valid1),
      .dout_ready(dout_ready), .overrun(overrun1), .clr_ovr(clr_ovr),
      .parity_err(parity_err1)
   );

   // Scoreboard: a word is new when valid appears after an idle or consumed slot.
   always @(negedge clk) begin
      if (!rst_n) begin
         pv = 1'b0;
         pr = 1'b0;
      end else begin
         if (dout_valid && (!pv || pr)) begin
            logic [8:0] exp;
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected: got dout=%h perr=%b, expected no word", dout, parity_err);
            end else begin
               exp = sb.pop_front();
               if ({parity_err, dout} !== exp) begin
                  bad++;
                  $display("FAIL sb_word: got perr=%b dout=%h, expected perr=%b dout=%h",
                           parity_err, dout, exp[8], exp[7:0]);
               end
            end
         end
         pv = dout_valid;
         pr = dout_ready;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input int gap, input logic fs);
      din        = b;
      din_valid  = 1'b1;
      frame_sync = fs;
      tick();
      din        = 1'b0;
      din_valid  = 1'b0;
      frame_sync = 1'b0;
      repeat (gap) tick();
   endtask

   // Sends w MSB-first (plus parity bit when enabled). perr injects a wrong parity.
   task automatic send_word(input logic [7:0] w, input int gap, input logic perr,
                            input logic expect_it, input logic rdy_last, input logic clr_last);
      logic [8:0] seq;
      seq = {w, (^w) ^ perr};
      if (expect_it) sb.push_back({perr, w});
      for (int j = 0; j < NBITS; j++) begin
         if (j == NBITS - 1) begin
            if (rdy_last) dout_ready = 1'b1;
            if (clr_last) clr_ovr = 1'b1;
         end
         send_bit(seq[8-j], (j == NBITS - 1) ? 0 : gap, 1'b0);
      end
      clr_ovr = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick();
      tick();
      total++; if (dout !== 8'h00) begin bad++; $display("FAIL rst_dout: got %h, expected 00", dout); end
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, expected 0", dout_valid); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_ovr: got %b, expected 0", overrun); end
      total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL rst_perr: got %b, expected 0", parity_err); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic;
      dout_ready = 1'b1;
      send_word(8'hA5, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b, expected 1", dout_valid); end
      total++; if (dout !== 8'hA5) begin bad++; $display("FAIL basic_dout: got %h, expected a5", dout); end
      total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL basic_perr: got %b, expected 0", parity_err); end
      tick();
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL basic_one_clk: got %b, expected 0", dout_valid); end
   endtask

   task automatic test_gaps;
      logic [8:0] seq;
      int         early;
      early = 0;
      seq   = {8'hA5, ^8'hA5};
      sb.push_back({1'b0, 8'hA5});
      for (int j = 0; j < NBITS; j++) begin
         send_bit(seq[8-j], (j == NBITS - 1) ? 0 : 3, 1'b0);
         if (j != NBITS - 1 && dout_valid !== 1'b0) early++;
      end
      total++; if (early != 0) begin bad++; $display("FAIL gaps_early: got %0d early valids, expected 0", early); end
      total++; if (dout !== 8'hA5 || dout_valid !== 1'b1) begin
         bad++; $display("FAIL gaps_word: got %h/%b, expected a5/1", dout, dout_valid); end
      tick();
   endtask

   task automatic test_overrun;
      dout_ready = 1'b0;
      send_word(8'hA5, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      send_word(8'h3C, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (dout !== 8'hA5) begin bad++; $display("FAIL ovr_hold: got %h, expected a5", dout); end
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b, expected 1", overrun); end
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr: got %b, expected 0", overrun); end
      // drop coinciding with clr_ovr: the set must win
      send_word(8'h77, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins: got %b, expected 1", overrun); end
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      dout_ready = 1'b1;
      tick();
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain: got %b, expected 0", dout_valid); end
      total++; if (dout !== 8'hA5 || overrun !== 1'b0) begin
         bad++; $display("FAIL ovr_after: got %h/%b, expected a5/0", dout, overrun); end
   endtask

   task automatic test_consume_complete;
      dout_ready = 1'b0;
      send_word(8'h5A, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      send_word(8'hC3, 0, 1'b0, 1'b1, 1'b1, 1'b0);
      total++; if (dout !== 8'hC3 || dout_valid !== 1'b1) begin
         bad++; $display("FAIL cc_word: got %h/%b, expected c3/1", dout, dout_valid); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL cc_ovr: got %b, expected 0", overrun); end
      tick();
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL cc_drain: got %b, expected 0", dout_valid); end
   endtask

   task automatic test_frame_sync;
      send_bit(1'b1, 0, 1'b0);
      send_bit(1'b1, 0, 1'b0);
      send_bit(1'b0, 0, 1'b0);
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      send_word(8'h3C, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++; if (dout !== 8'h3C || dout_valid !== 1'b1) begin
         bad++; $display("FAIL fsync_word: got %h/%b, expected 3c/1", dout, dout_valid); end
      tick();
   endtask

   task automatic test_sync_bit0;
      logic [7:0] w;
      w = 8'h81;
      for (int j = 0; j < 5; j++) send_bit(1'b0, 0, 1'b0);
      sb.push_back({1'b0, w});
      send_bit(w[7], 0, 1'b1);
      for (int i = 6; i >= 0; i--) send_bit(w[i], 0, 1'b0);
`ifdef SIPO_PARITY_EN
      send_bit(^w, 0, 1'b0);
`endif
      total++; if (dout !== 8'h81 || dout_valid !== 1'b1) begin
         bad++; $display("FAIL sync_bit0: got %h/%b, expected 81/1", dout, dout_valid); end
      tick();
   endtask

   task automatic test_reset_midword;
      send_bit(1'b1, 0, 1'b0);
      send_bit(1'b0, 0, 1'b0);
      send_bit(1'b1, 0, 1'b0);
      send_bit(1'b1, 0, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      total++; if (dout !== 8'h00 || dout_valid !== 1'b0 || overrun !== 1'b0 || parity_err !== 1'b0) begin
         bad++; $display("FAIL midrst_outs: got %h/%b/%b/%b, expected 00/0/0/0", dout, dout_valid, overrun, parity_err); end
      send_word(8'h96, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++; if (dout !== 8'h96) begin bad++; $display("FAIL midrst_word: got %h, expected 96", dout); end
      tick();
   endtask

   task automatic test_lsb_first;
      // serial 0,0,0,1,0,0,1,0 is 8'h12 sent MSB-first
      send_word(8'h12, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++; if (dout1 !== 8'h48 || dout_valid1 !== 1'b1) begin
         bad++; $display("FAIL lsb_word: got %h/%b, expected 48/1", dout1, dout_valid1); end
      tick();
   endtask

`ifdef SIPO_PARITY_EN
   task automatic test_parity;
      logic [7:0] w;
      w = 8'hA5;
      send_word(w, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_good: got %b, expected 0", parity_err); end
      tick();
      sb.push_back({1'b1, w});
      for (int i = 7; i >= 0; i--) send_bit(w[i], 0, 1'b0);
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL par_early: got %b, expected 0", dout_valid); end
      send_bit(~(^w), 0, 1'b0);
      total++; if (parity_err !== 1'b1 || dout_valid !== 1'b1) begin
         bad++; $display("FAIL par_bad: got %b/%b, expected 1/1", parity_err, dout_valid); end
      tick();
   endtask
`endif

   task automatic test_back_to_back;
      logic [7:0] words [3];
      words = '{8'h01, 8'hFE, 8'h6B};
      foreach (words[k]) send_word(words[k], 0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++; if (dout !== 8'h6B) begin bad++; $display("FAIL b2b_last: got %h, expected 6b", dout); end
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_overrun();
      test_consume_complete();
      test_frame_sync();
      test_sync_bit0();
      test_reset_midword();
      test_lsb_first();
`ifdef SIPO_PARITY_EN
      test_parity();
`endif
      test_back_to_back();
      total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d words, expected 0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
